// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Brief   : Shared keyboard op codes, FSM states and grid defaults.
// Revision: 1.0
// ============================================================================
package game_pkg;

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_SELECT = 3'd1;
    localparam logic [2:0] OP_CANCEL = 3'd2;
    localparam logic [2:0] OP_LEFT   = 3'd3;
    localparam logic [2:0] OP_RIGHT  = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;

    localparam int DEFAULT_COLS = 8;
    localparam int DEFAULT_ROWS = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECTED = 2'd1,
        ST_REQUEST  = 2'd2
    } state_t;

    // Plain integer distance, so 0 and COLS-1 are never treated as adjacent.
    function automatic logic diff_one(input int a, input int b);
        return ((a - b) == 1) || ((b - a) == 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : cursor_ctrl_if
// Brief   : Operation input, cursor/selection outputs and swap handshake.
// Revision: 1.0
// ============================================================================
interface cursor_ctrl_if #(
    parameter int XW = 3,
    parameter int YW = 3
);
    logic [2:0]    operation;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic          sel_valid;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic          swap_req;
    logic [XW-1:0] src_x;
    logic [YW-1:0] src_y;
    logic [XW-1:0] dst_x;
    logic [YW-1:0] dst_y;
    logic          swap_ack;

    modport master (
        input  operation, swap_ack,
        output cursor_x, cursor_y, sel_valid, sel_x, sel_y,
               swap_req, src_x, src_y, dst_x, dst_y
    );

    modport slave (
        output operation, swap_ack,
        input  cursor_x, cursor_y, sel_valid, sel_x, sel_y,
               swap_req, src_x, src_y, dst_x, dst_y
    );
endinterface
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
// Module  : key_repeat
// Brief   : Turns held operation levels into press events with auto-repeat.
// Revision: 1.0
// ============================================================================
module key_repeat
    import game_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [2:0] operation,
    output logic            evt,
    output logic [2:0]      evt_op
);

    localparam int c_max_period = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_cnt_w      = $clog2(c_max_period + 1);
    localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(REPEAT_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(REPEAT_RATE - 1);

    logic [2:0]         w_op;
    logic [2:0]         r_op_q;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_first;
    logic               w_press;
    logic               w_hold;
    logic               w_rpt;

    // Reserved code 7 is folded to "none" before edge detection.
    assign w_op    = (operation == 3'd7) ? OP_NONE : operation;
    assign w_press = (w_op != r_op_q) && (w_op != OP_NONE);
    assign w_hold  = (w_op == r_op_q) && (w_op >= OP_LEFT) && (w_op <= OP_DOWN);
    assign w_rpt   = w_hold && (r_first ? (r_cnt == c_delay_last) : (r_cnt == c_rate_last));

    assign evt    = w_press || w_rpt;
    assign evt_op = w_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_q  <= OP_NONE;
            r_cnt   <= '0;
            r_first <= 1'b1;
        end else begin
            r_op_q <= w_op;
            if (w_rpt) begin
                r_cnt   <= '0;
                r_first <= 1'b0;
            end else if (w_hold) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end else begin
                r_cnt   <= '0;
                r_first <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cursor_ctrl
// Brief   : Wrapping grid cursor plus select/swap-request FSM.
// Revision: 1.0
// ============================================================================
module cursor_ctrl
    import game_pkg::*;
#(
    parameter int COLS         = DEFAULT_COLS,
    parameter int ROWS         = DEFAULT_ROWS,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cursor_ctrl_if.master bus
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW-1:0] c_x_max = XW'(COLS - 1);
    localparam logic [YW-1:0] c_y_max = YW'(ROWS - 1);

    logic          w_evt;
    logic [2:0]    w_evt_op;

    state_t        r_state, w_state;
    logic [XW-1:0] r_cx, w_cx, r_sx, w_sx, r_srcx, w_srcx, r_dstx, w_dstx;
    logic [YW-1:0] r_cy, w_cy, r_sy, w_sy, r_srcy, w_srcy, r_dsty, w_dsty;
    logic          r_sel_valid, w_sel_valid, r_req, w_req;
    logic          w_sel_hit, w_adj;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_repeat (
        .clk       (clk),
        .rst       (rst),
        .operation (bus.operation),
        .evt       (w_evt),
        .evt_op    (w_evt_op)
    );

    assign w_sel_hit = (r_cx == r_sx) && (r_cy == r_sy);
    assign w_adj     = ((r_cx == r_sx) && diff_one(int'(r_cy), int'(r_sy))) ||
                       ((r_cy == r_sy) && diff_one(int'(r_cx), int'(r_sx)));

    always_comb begin
        w_state     = r_state;
        w_cx        = r_cx;
        w_cy        = r_cy;
        w_sel_valid = r_sel_valid;
        w_sx        = r_sx;
        w_sy        = r_sy;
        w_req       = r_req;
        w_srcx      = r_srcx;
        w_srcy      = r_srcy;
        w_dstx      = r_dstx;
        w_dsty      = r_dsty;

        // The cursor is frozen while a swap is outstanding.
        if (w_evt && (r_state != ST_REQUEST)) begin
            case (w_evt_op)
                OP_LEFT:  w_cx = (r_cx == '0)      ? c_x_max : r_cx - XW'(1);
                OP_RIGHT: w_cx = (r_cx == c_x_max) ? '0      : r_cx + XW'(1);
                OP_UP:    w_cy = (r_cy == '0)      ? c_y_max : r_cy - YW'(1);
                OP_DOWN:  w_cy = (r_cy == c_y_max) ? '0      : r_cy + YW'(1);
                default:  ;
            endcase
        end

        case (r_state)
            ST_IDLE: begin
                if (w_evt && (w_evt_op == OP_SELECT)) begin
                    w_sx        = r_cx;
                    w_sy        = r_cy;
                    w_sel_valid = 1'b1;
                    w_state     = ST_SELECTED;
                end
            end
            ST_SELECTED: begin
                if (w_evt && (w_evt_op == OP_SELECT)) begin
                    if (w_sel_hit) begin
                        w_sel_valid = 1'b0;
                        w_state     = ST_IDLE;
                    end else if (w_adj) begin
                        w_srcx  = r_sx;
                        w_srcy  = r_sy;
                        w_dstx  = r_cx;
                        w_dsty  = r_cy;
                        w_req   = 1'b1;
                        w_state = ST_REQUEST;
                    end else begin
                        w_sx = r_cx;
                        w_sy = r_cy;
                    end
                end else if (w_evt && (w_evt_op == OP_CANCEL)) begin
                    w_sel_valid = 1'b0;
                    w_state     = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (bus.swap_ack) begin
                    w_req       = 1'b0;
                    w_sel_valid = 1'b0;
                    w_state     = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cx        <= '0;
            r_cy        <= '0;
            r_sel_valid <= 1'b0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_req       <= 1'b0;
            r_srcx      <= '0;
            r_srcy      <= '0;
            r_dstx      <= '0;
            r_dsty      <= '0;
        end else begin
            r_state     <= w_state;
            r_cx        <= w_cx;
            r_cy        <= w_cy;
            r_sel_valid <= w_sel_valid;
            r_sx        <= w_sx;
            r_sy        <= w_sy;
            r_req       <= w_req;
            r_srcx      <= w_srcx;
            r_srcy      <= w_srcy;
            r_dstx      <= w_dstx;
            r_dsty      <= w_dsty;
        end
    end

    assign bus.cursor_x  = r_cx;
    assign bus.cursor_y  = r_cy;
    assign bus.sel_valid = r_sel_valid;
    assign bus.sel_x     = r_sx;
    assign bus.sel_y     = r_sy;
    assign bus.swap_req  = r_req;
    assign bus.src_x     = r_srcx;
    assign bus.src_y     = r_srcy;
    assign bus.dst_x     = r_dstx;
    assign bus.dst_y     = r_dsty;

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cursor_ctrl
// Brief   : Table-driven self-checking bench for cursor_ctrl.
// Revision: 1.0
// ============================================================================
module tb_cursor_ctrl;

    typedef struct {
        logic [2:0] op;
        logic       ack;
        int cx, cy, sv, sx, sy, req, srx, sry, dsx, dsy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    cursor_ctrl_if #(.XW(3), .YW(3)) bus ();

    cursor_ctrl #(
        .COLS         (8),
        .ROWS         (8),
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        if (exp >= 0) begin
            checks++;
            if (act != exp) begin
                failures++;
                $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
            end
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, ".cursor_x"},  int'(bus.cursor_x),  e.cx);
        chk({tag, ".cursor_y"},  int'(bus.cursor_y),  e.cy);
        chk({tag, ".sel_valid"}, int'(bus.sel_valid), e.sv);
        chk({tag, ".sel_x"},     int'(bus.sel_x),     e.sx);
        chk({tag, ".sel_y"},     int'(bus.sel_y),     e.sy);
        chk({tag, ".swap_req"},  int'(bus.swap_req),  e.req);
        chk({tag, ".src_x"},     int'(bus.src_x),     e.srx);
        chk({tag, ".src_y"},     int'(bus.src_y),     e.sry);
        chk({tag, ".dst_x"},     int'(bus.dst_x),     e.dsx);
        chk({tag, ".dst_y"},     int'(bus.dst_y),     e.dsy);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic ack, input int cx, input int cy,
                                input int sv, input int sx, input int sy, input int req,
                                input int srx, input int sry, input int dsx, input int dsy);
        vec_t v;
        v.op = op; v.ack = ack; v.cx = cx; v.cy = cy; v.sv = sv; v.sx = sx; v.sy = sy;
        v.req = req; v.srx = srx; v.sry = sry; v.dsx = dsx; v.dsy = dsy;
        return v;
    endfunction

    // Non-request vector: src/dst are don't-care.
    task automatic add(input logic [2:0] op, input logic ack, input int cx, input int cy,
                       input int sv, input int sx, input int sy);
        tbl.push_back(mk(op, ack, cx, cy, sv, sx, sy, 0, -1, -1, -1, -1));
    endtask

    // Drive one cycle of stimulus (called #1 after a rising edge), check after the next edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        bus.operation = v.op;
        bus.swap_ack  = v.ack;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_all(tag, e);
    endtask

    initial begin
        vec_t z;
        vec_t r;
        int   n;
        bus.operation = 3'd0;
        bus.swap_ack  = 1'b0;

        // Tap right, left/up wrap, code 7 release, direct change, stray ack.
        add(4,0,1,0,0,0,0); add(4,0,1,0,0,0,0); add(4,0,1,0,0,0,0); add(0,0,1,0,0,0,0);
        add(4,0,2,0,0,0,0); add(0,0,2,0,0,0,0);
        add(3,0,1,0,0,0,0); add(0,0,1,0,0,0,0); add(3,0,0,0,0,0,0); add(0,0,0,0,0,0,0);
        add(3,0,7,0,0,0,0); add(7,0,7,0,0,0,0); add(5,0,7,7,0,0,0); add(0,0,7,7,0,0,0);
        add(4,0,0,7,0,0,0); add(6,0,0,0,0,0,0); add(0,0,0,0,0,0,0); add(0,1,0,0,0,0,0);
        // Select / deselect / reselect / cancel around (1,1) and (3,3).
        add(4,0,1,0,0,0,0); add(0,0,1,0,0,0,0); add(6,0,1,1,0,0,0); add(0,0,1,1,0,0,0);
        add(1,0,1,1,1,1,1); add(0,0,1,1,1,1,1); add(1,0,1,1,0,1,1); add(0,0,1,1,0,1,1);
        add(1,0,1,1,1,1,1); add(0,0,1,1,1,1,1);
        add(4,0,2,1,1,1,1); add(0,0,2,1,1,1,1); add(4,0,3,1,1,1,1); add(0,0,3,1,1,1,1);
        add(6,0,3,2,1,1,1); add(0,0,3,2,1,1,1); add(6,0,3,3,1,1,1); add(0,0,3,3,1,1,1);
        add(1,0,3,3,1,3,3); add(2,0,3,3,0,3,3); add(0,0,3,3,0,3,3);
        add(2,0,3,3,0,3,3); add(0,0,3,3,0,3,3);
        // Swap (2,2)->(3,2); moves frozen; ack wins over a same-cycle select.
        add(3,0,2,3,0,3,3); add(0,0,2,3,0,3,3); add(5,0,2,2,0,3,3); add(0,0,2,2,0,3,3);
        add(1,0,2,2,1,2,2); add(0,0,2,2,1,2,2); add(4,0,3,2,1,2,2); add(0,0,3,2,1,2,2);
        tbl.push_back(mk(1,0,3,2,1,2,2,1,2,2,3,2));
        tbl.push_back(mk(0,0,3,2,1,2,2,1,2,2,3,2));
        tbl.push_back(mk(3,0,3,2,1,2,2,1,2,2,3,2));
        tbl.push_back(mk(0,0,3,2,1,2,2,1,2,2,3,2));
        add(1,1,3,2,0,2,2); add(0,0,3,2,0,2,2);
        add(1,0,3,2,1,3,2); add(0,0,3,2,1,3,2); add(2,0,3,2,0,3,2); add(0,0,3,2,0,3,2);

        z = mk(0,0,0,0,0,0,0,0,0,0,0,0);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", z);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Auto-repeat: hold right for 40 cycles from x=3.
        for (int k = 0; k < 40; k++) begin
            n = 1 + ((k >= 20) ? (1 + (k - 20) / 5) : 0);
            apply(mk(4,0,(3 + n) % 8,2,0,3,2,0,-1,-1,-1,-1), $sformatf("rpt%0d", k));
        end
        for (int k = 0; k < 10; k++) apply(mk(0,0,0,2,0,3,2,0,-1,-1,-1,-1), $sformatf("rel%0d", k));

        // Select never repeats.
        for (int k = 0; k < 25; k++) apply(mk(1,0,0,2,1,0,2,0,-1,-1,-1,-1), $sformatf("selhold%0d", k));
        apply(mk(0,0,0,2,1,0,2,0,-1,-1,-1,-1), "selrel");
        apply(mk(4,0,1,2,1,0,2,0,-1,-1,-1,-1), "pre_swap_mv");
        apply(mk(0,0,1,2,1,0,2,0,-1,-1,-1,-1), "pre_swap_rel");
        r = mk(1,0,1,2,1,0,2,1,0,2,1,2);
        apply(r, "req_start");
        r.op = 3'd0;
        apply(r, "req_hold");

        // Asynchronous reset in the middle of the request.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("rst_async", z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(0,1,0,0,0,0,0,0,0,0,0,0), "ack_after_rst");
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0), "idle_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
